// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF frame path.
package spdif_pkg;

  localparam int SPDIF_BLOCK_FRAMES = 192;

  // Channel-status bit positions within the 192-bit block
  localparam int CS_COPY    = 2;
  localparam int CS_CAT_LSB = 8;
  localparam int CS_FS_LSB  = 24;
  localparam int CS_WL_LSB  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_L = 2'd1,
    SEND_R = 2'd2
  } sched_state_t;

  // Channel-status fields that are not hard-wired to zero
  typedef struct packed {
    logic       copy_permit;
    logic [7:0] category;
    logic [3:0] fs;
    logic [3:0] word_length;
  } cs_cfg_t;

endpackage

// File: rtl/spdif_channel_status_gen.sv
// Maps a frame number and the latched configuration to that frame's C bit.
module spdif_channel_status_gen
  import spdif_pkg::*;
(
  input  logic [7:0] frame_index,
  input  cs_cfg_t    cfg,
  output logic       c_bit
);

  // First 64 channel-status bits; everything above is zero (consumer, PCM, mode 0)
  logic [63:0] cs_word;

  // Assemble the low part of the channel-status block from the config fields
  always_comb begin
    cs_word                   = '0;
    cs_word[CS_COPY]          = cfg.copy_permit;
    cs_word[CS_CAT_LSB +: 8]  = cfg.category;
    cs_word[CS_FS_LSB  +: 4]  = cfg.fs;
    cs_word[CS_WL_LSB  +: 4]  = cfg.word_length;
  end

  // Select the bit for this frame; frames 64 and up always carry 0
  always_comb begin
    c_bit = (frame_index[7:6] == 2'b00) ? cs_word[frame_index[5:0]] : 1'b0;
  end

endmodule

// File: rtl/spdif_frame_scheduler.sv
// Splits accepted stereo pairs into left/right sub-frames for the encoder,
// tracks the channel-status block position and generates the C bit.
module spdif_frame_scheduler
  import spdif_pkg::*;
#(
  parameter int BLOCK_FRAMES = SPDIF_BLOCK_FRAMES
) (
  input  logic        clk128,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [23:0] i_left,
  input  logic [23:0] i_right,
  input  logic        i_mute,
  input  logic        i_cs_copy_permit,
  input  logic [7:0]  i_cs_category,
  input  logic [3:0]  i_cs_fs,
  input  logic [3:0]  i_cs_word_length,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_is_frame_start,
  output logic        o_is_left,
  output logic [23:0] o_audio,
  output logic        o_user,
  output logic        o_control,
  output logic [7:0]  o_frame_index
);

  localparam logic [7:0] LAST_FRAME = 8'(BLOCK_FRAMES - 1);

  sched_state_t state, state_nxt;

  logic        accept;     // pair taken this edge
  logic        ld_right;   // left sub-frame handed off, present right
  logic        drop;       // right handed off with nothing to follow

  logic [7:0]  frame_cnt;  // frame being presented, or next frame when idle
  logic [7:0]  frame_inc;
  logic [7:0]  acc_idx;    // frame number the pair accepted now will carry
  logic [23:0] right_word;
  cs_cfg_t     cs_cfg;     // configuration latched at block start
  cs_cfg_t     cs_in;
  cs_cfg_t     cs_use;
  logic        c_acc;

  assign cs_in = '{copy_permit: i_cs_copy_permit, category: i_cs_category,
                   fs: i_cs_fs, word_length: i_cs_word_length};

  assign frame_inc = (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
  // A pair accepted from SEND_R follows the frame currently on the wire
  assign acc_idx   = (state == SEND_R) ? frame_inc : frame_cnt;
  // Frame 0 uses the config being latched at that same edge
  assign cs_use    = (acc_idx == 8'd0) ? cs_in : cs_cfg;
  assign o_user    = 1'b0;

  spdif_channel_status_gen u_cs_gen (
    .frame_index (acc_idx),
    .cfg         (cs_use),
    .c_bit       (c_acc)
  );

  // State register
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = SEND_L;
      SEND_L:  if (o_ready) state_nxt = SEND_R;
      SEND_R:  if (o_ready) state_nxt = i_valid ? SEND_L : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and load strobes; i_ready depends only on state and o_ready
  always_comb begin
    i_ready  = 1'b0;
    ld_right = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE:    i_ready = 1'b1;
      SEND_L:  ld_right = o_ready;
      SEND_R: begin
        i_ready = o_ready;
        drop    = o_ready & ~i_valid;
      end
      default: i_ready = 1'b0;
    endcase
    accept = i_valid & i_ready;
  end

  // Sub-frame output registers, frame counter and block config latch
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      o_valid          <= 1'b0;
      o_is_frame_start <= 1'b0;
      o_is_left        <= 1'b0;
      o_audio          <= '0;
      o_control        <= 1'b0;
      o_frame_index    <= '0;
      frame_cnt        <= '0;
      right_word       <= '0;
      cs_cfg           <= '0;
    end else if (accept) begin
      o_valid          <= 1'b1;
      o_is_left        <= 1'b1;
      o_is_frame_start <= (acc_idx == 8'd0);
      o_audio          <= i_mute ? 24'd0 : i_left;
      o_control        <= c_acc;
      o_frame_index    <= acc_idx;
      frame_cnt        <= acc_idx;
      right_word       <= i_mute ? 24'd0 : i_right;
      if (acc_idx == 8'd0) cs_cfg <= cs_in;
    end else if (ld_right) begin
      o_is_left        <= 1'b0;
      o_is_frame_start <= 1'b0;
      o_audio          <= right_word;
    end else if (drop) begin
      o_valid          <= 1'b0;
      frame_cnt        <= frame_inc;
    end
  end

endmodule

// File: doc/spdif_frame_scheduler.md
# spdif_frame_scheduler

Sequences stereo PCM sample pairs into the S/PDIF sub-frame encoder: splits each pair into left/right sub-frames and tracks the 192-frame channel-status block. It also generates the per-sub-frame channel-status (C) bit from a latched configuration and marks the block-start (B-preamble) sub-frame. It sits between the sample source (FIFO/resampler) and the sub-frame encoder's valid/ready input.

## Interface
- BLOCK_FRAMES, default 192: frames per channel-status block; counter wraps at BLOCK_FRAMES-1.
- clk128  in  1  bit clock (128×fs), all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- i_valid  in  1  sample pair valid
- i_ready  out  1  pair accepted when i_valid && i_ready
- i_left  in  24  left sample, LSB-aligned
- i_right  in  24  right sample
- i_mute  in  1  sampled at pair acceptance; 1 forces both audio words to 0
- i_cs_copy_permit  in  1  channel-status bit 2
- i_cs_category  in  8  channel-status bits 8..15, bit 8+k = i_cs_category[k]
- i_cs_fs  in  4  channel-status bits 24..27, bit 24+k = i_cs_fs[k]
- i_cs_word_length  in  4  channel-status bits 32..35, bit 32+k = i_cs_word_length[k]
- o_valid  out  1  sub-frame valid to encoder
- o_ready  in  1  encoder ready
- o_is_frame_start  out  1  1 only on the left sub-frame of frame 0
- o_is_left  out  1  1 on left sub-frame
- o_audio  out  24  sub-frame audio
- o_user  out  1  constant 0
- o_control  out  1  channel-status bit for current frame
- o_frame_index  out  8  frame number of the sub-frame presented (0..BLOCK_FRAMES-1)

## Operation
- FSM states: IDLE, SEND_L, SEND_R.
- IDLE: i_ready=1, o_valid=0. On accept: latch right word and mute, load o_* with left sub-frame, go SEND_L.
- SEND_L: o_valid=1, i_ready=0. On o_valid&&o_ready: load o_* with right sub-frame (same frame index, same o_control), go SEND_R.
- SEND_R: o_valid=1; i_ready=o_ready. On o_ready: frame index += 1 (BLOCK_FRAMES-1 wraps to 0). If i_valid is also high, accept the next pair and go to SEND_L with its left sub-frame (back-to-back); otherwise clear o_valid and go to IDLE.
- Channel status: latched copy of the four cs inputs is updated only when a pair is accepted with next frame index 0. Mid-block input changes are ignored until the next block.
- C bit for frame n, applied to both sub-frames: bit 2 = copy_permit; 8..15 category; 24..27 fs; 32..35 word_length; all other bits 0 (consumer, PCM, no emphasis, mode 0).
- o_frame_index reflects the latched sub-frame's frame.
- Reset values: state IDLE, frame index 0, o_valid 0, o_is_frame_start 0, o_is_left 0, o_audio 0, o_user 0, o_control 0, o_frame_index 0, latched config 0, i_ready 1 after reset release.
- Reset mid-operation: the current pair is discarded and the encoder sees o_valid drop immediately. The next accepted pair is frame 0 with o_is_frame_start=1.
- Underrun: none inserted here. If no pair is available the FSM idles, and underrun is flagged downstream by the encoder.

## Timing
- All o_* are registered; i_ready is combinational from state and o_ready only.
- Accept at edge t: left sub-frame is valid from t+1.
- Left handshake at edge u: right sub-frame is presented from u+1.
- Right handshake plus accept at edge v: next left sub-frame from v+1, with no gap cycle.
- While o_valid && !o_ready, all o_* are held stable.

## Structure
- Shared package spdif_pkg:
  - SPDIF_BLOCK_FRAMES = 192.
  - Channel-status bit-position constants: CS_COPY = 2, CS_CAT_LSB = 8, CS_FS_LSB = 24, CS_WL_LSB = 32.
  - FSM state typedef.
- Sub-module spdif_channel_status_gen: combinational; maps frame index and latched config to the C bit.

## Test plan
- Basic pair: after reset, send L=0x123456, R=0xABCDEF with o_ready=1.
  - Cycle 1: left sub-frame with is_left=1, frame_start=1, audio 0x123456.
  - Next cycle: is_left=0, frame_start=0, audio 0xABCDEF, frame_index 0.
- Encoder stall: hold o_ready=0 for 10 cycles in SEND_L, then in SEND_R. o_* stay constant and i_ready=0 throughout; no pair is lost.
- Block wrap: stream 193 pairs back-to-back.
  - Both sub-frames of every frame appear with no gap cycle.
  - frame_start is 1 only at frames 0 and 192.
  - frame_index goes 191 -> 0.
- Channel status: copy_permit=1, category=0x82, fs=4'b0100, word_length=4'b1011, over one block.
  - o_control=1 exactly at frames 2, 9, 15, 26, 32, 33, 35; identical on L and R.
- Config change: change category at frame 100. o_control for frames 100-191 is unchanged; the new value appears from frame 0 of the next block.
- Mute and reset:
  - i_mute=1 gives audio 0 while o_control is unchanged.
  - Reset asserted in SEND_R: outputs drop to 0 in the same cycle. The next pair is presented with frame_start=1 and frame_index 0.
